digit_drawer: RTL and testbench
===============================

DIGIT_DRAWER -- requirements
Module: digit_drawer

Interface
REQ-001 Parameter SEG_LEN, default 7: pixels per segment; legal range 2..15.
REQ-002 Parameter X_ORG, default 11: glyph left-edge offset from xIn; X_ORG+SEG_LEN-1 SHALL be <= 31.
REQ-003 Parameter Y_ORG, default 7: glyph top-edge offset from yIn; Y_ORG+2*SEG_LEN-2 SHALL be <= 31.
REQ-004 Parameter HEX_EN, default 1: 1 = digits 10..15 drawn as A,b,C,d,E,F; 0 = digits 10..15 are blank.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 resetn  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-007 start  input  1  request to draw one glyph; sampled only in IDLE.
REQ-008 abort  input  1  cancel current glyph.
REQ-009 digit  input  4  glyph code, captured on start acceptance.
REQ-010 xIn  input  8  tile origin x, captured on start acceptance.
REQ-011 yIn  input  7  tile origin y, captured on start acceptance.
REQ-012 xOut  output  8  pixel x, valid when plot=1.
REQ-013 yOut  output  7  pixel y, valid when plot=1.
REQ-014 plot  output  1  one pixel per cycle when high.
REQ-015 busy  output  1  high from the cycle after start acceptance until the cycle after done.
REQ-016 done  output  1  one-cycle pulse at glyph completion.

Function
REQ-017 States: IDLE, SCAN, DRAW, DONE; all outputs registered.
REQ-018 IDLE: start=1 at an edge SHALL capture digit/xIn/yIn, load the 7-bit segment mask (bit0=a..bit6=g) from the package table, and go to SCAN.
REQ-019 SCAN (1 cycle): lowest set mask bit selects the segment and goes to DRAW with step=0; empty mask goes to DONE.
REQ-020 DRAW: plot=1 for exactly SEG_LEN consecutive cycles, step 0..SEG_LEN-1; after the last step, clear that mask bit and return to SCAN.
REQ-021 Segment geometry (start offset, direction; L=SEG_LEN): a (0,0) +x; b (L-1,0) +y; c (L-1,L-1) +y; d (0,2L-2) +x; e (0,L-1) +y; f (0,0) +y; g (0,L-1) +x; corner pixels repeat.
REQ-022 xOut = xIn + X_ORG + dx, modulo 256; yOut = yIn + Y_ORG + dy, modulo 128; wraparound is not flagged.
REQ-023 DONE: done=1 for one cycle, then IDLE; busy deasserts in IDLE.
REQ-024 start while not in IDLE SHALL be ignored, not queued.
REQ-025 abort=1 in SCAN/DRAW/DONE SHALL force IDLE at the next edge with plot=0 and no done pulse; abort has priority over start in the same cycle.
REQ-026 Busy duration = N*(SEG_LEN+1)+2 cycles, where N = number of lit segments.
REQ-027 When plot=0, xOut/yOut SHALL hold their last values.

Reset
REQ-028 resetn=0 SHALL immediately force IDLE with plot, busy and done = 0, xOut/yOut = 0, mask = 0 and step = 0, including mid-glyph.
REQ-029 The first start is accepted at the first rising edge after resetn deasserts.

Structure
REQ-030 Shared package: the 16-entry segment-mask table (0..9, A..F), segment index constants, the state enumeration, and the per-segment direction encoding.
REQ-031 One sub-module, seg_stepper: takes a start offset, direction and length, and emits a 5-bit dx/dy with a last flag.

Verification
REQ-032 Default params, digit=7, xIn=0, yIn=0 -> 21 plots (segments a,b,c); first pixel (11,7); last pixel (17,19); done at busy cycle 26.
REQ-033 digit=8 -> 49 plots in segment order a..g; busy for 58 cycles.
REQ-034 HEX_EN=0, digit=12 -> no plot; done asserts 2 cycles after start; busy low after 3 cycles.
REQ-035 xIn=250, yIn=125, digit=1 -> first pixel x=(250+17) mod 256=11, y=(125+7) mod 128=4.
REQ-036 start pulsed in DRAW -> no effect; abort at plot #5 -> IDLE next edge, no done; resetn low mid-DRAW -> outputs 0 immediately.

Source files
------------

// File: rtl/digit_drawer_pkg.sv
// Shared definitions for the seven-segment glyph plotter.
//   - FSM state enumeration
//   - segment index constants (a..g = 0..6) and direction encoding
//   - 16-entry segment-mask table for glyphs 0..9, A, b, C, d, E, F
//   - helpers: per-segment start offset/direction, lowest-set-segment pick
package digit_drawer_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAW, ST_DONE} stateT;

  typedef enum logic {DIR_X, DIR_Y} dirT;

  localparam logic [2:0] SEG_A = 3'd0;
  localparam logic [2:0] SEG_B = 3'd1;
  localparam logic [2:0] SEG_C = 3'd2;
  localparam logic [2:0] SEG_D = 3'd3;
  localparam logic [2:0] SEG_E = 3'd4;
  localparam logic [2:0] SEG_F = 3'd5;
  localparam logic [2:0] SEG_G = 3'd6;

  // bit0 = segment a ... bit6 = segment g
  localparam logic [6:0] SEG_MASK [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct packed {
    logic [4:0] x0;
    logic [4:0] y0;
    dirT        dir;
  } segGeomT;

  // Start offset and stroke direction of a segment for a glyph of stroke len.
  // Vertical strokes share their end pixels with the horizontal ones.
  function automatic segGeomT segGeom(input logic [2:0] seg, input logic [4:0] len);
    logic [4:0] lm1;
    logic [4:0] bot;
    lm1 = len - 5'd1;
    bot = (len << 1) - 5'd2;
    case (seg)
      SEG_A:   segGeom = '{x0: 5'd0, y0: 5'd0, dir: DIR_X};
      SEG_B:   segGeom = '{x0: lm1,  y0: 5'd0, dir: DIR_Y};
      SEG_C:   segGeom = '{x0: lm1,  y0: lm1,  dir: DIR_Y};
      SEG_D:   segGeom = '{x0: 5'd0, y0: bot,  dir: DIR_X};
      SEG_E:   segGeom = '{x0: 5'd0, y0: lm1,  dir: DIR_Y};
      SEG_F:   segGeom = '{x0: 5'd0, y0: 5'd0, dir: DIR_Y};
      default: segGeom = '{x0: 5'd0, y0: lm1,  dir: DIR_X};
    endcase
  endfunction

  // Index of the lowest set bit; segments are drawn in a..g order.
  function automatic logic [2:0] lowestSeg(input logic [6:0] m);
    lowestSeg = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (m[i]) lowestSeg = 3'(i);
    end
  endfunction

endpackage

// File: rtl/digit_drawer_if.sv
// Request/pixel bundle of the glyph plotter.
//   master: issues start/abort with digit and tile origin, receives pixels
//   slave : the plotter; returns xOut/yOut/plot plus busy/done status
interface digit_drawer_if;
  logic       start;
  logic       abort;
  logic [3:0] digit;
  logic [7:0] xIn;
  logic [6:0] yIn;
  logic [7:0] xOut;
  logic [6:0] yOut;
  logic       plot;
  logic       busy;
  logic       done;

  modport master (output start, abort, digit, xIn, yIn,
                  input  xOut, yOut, plot, busy, done);
  modport slave  (input  start, abort, digit, xIn, yIn,
                  output xOut, yOut, plot, busy, done);
endinterface

// File: rtl/digit_drawer_seg_stepper.sv
// Pixel offset generator for one straight segment.
//   x0, y0 : segment start offset inside the glyph
//   dir    : DIR_X advances dx, DIR_Y advances dy
//   len    : pixels in the segment
//   step   : pixel index along the segment
//   dx, dy : glyph-relative pixel offset
//   last   : step is the final pixel of the segment
module seg_stepper
  import digit_drawer_pkg::*;
(
  input  logic [4:0] x0,
  input  logic [4:0] y0,
  input  dirT        dir,
  input  logic [4:0] len,
  input  logic [3:0] step,
  output logic [4:0] dx,
  output logic [4:0] dy,
  output logic       last
);

  always_comb begin
    dx   = x0 + ((dir == DIR_X) ? {1'b0, step} : 5'd0);
    dy   = y0 + ((dir == DIR_Y) ? {1'b0, step} : 5'd0);
    last = ({1'b0, step} == (len - 5'd1));
  end

endmodule

// File: rtl/digit_drawer.sv
// Seven-segment glyph plotter: emits one pixel per cycle for each lit
// segment of a hex digit, offset by the captured tile origin.
//   clk    : clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : slave side of digit_drawer_if (start/abort/digit/xIn/yIn in,
//            xOut/yOut/plot/busy/done out, all outputs registered)
module digit_drawer
  import digit_drawer_pkg::*;
#(
  parameter int SEG_LEN = 7,
  parameter int X_ORG   = 11,
  parameter int Y_ORG   = 7,
  parameter int HEX_EN  = 1
) (
  input  logic           clk,
  input  logic           resetn,
  digit_drawer_if.slave  bus
);

  localparam logic [4:0] LEN = 5'(SEG_LEN);

  stateT      state, nextState;
  logic [6:0] mask, nextMask, loadMask;
  logic [2:0] seg, nextSeg;
  logic [3:0] step, nextStep;
  logic       lastReg;
  logic [7:0] xBase;
  logic [6:0] yBase;
  segGeomT    geom;
  logic [4:0] dx, dy;
  logic       stepLast;

  assign loadMask = (HEX_EN == 0 && bus.digit > 4'd9) ? 7'd0 : SEG_MASK[bus.digit];

  always_comb begin
    nextState = state;
    nextMask  = mask;
    nextSeg   = seg;
    nextStep  = step;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          nextState = ST_SCAN;
          nextMask  = loadMask;
        end
      end
      ST_SCAN: begin
        if (mask == 7'd0) begin
          nextState = ST_DONE;
        end else begin
          nextState = ST_DRAW;
          nextSeg   = lowestSeg(mask);
          nextStep  = 4'd0;
        end
      end
      ST_DRAW: begin
        if (lastReg) begin
          nextState = ST_SCAN;
          nextMask  = mask & ~(7'd1 << seg);
        end else begin
          nextStep = step + 4'd1;
        end
      end
      ST_DONE: nextState = ST_IDLE;
      default: nextState = ST_IDLE;
    endcase
    if (bus.abort && state != ST_IDLE) begin
      nextState = ST_IDLE;
      nextMask  = 7'd0;
      nextStep  = 4'd0;
    end
  end

  // The stepper looks at the upcoming segment/step so the pixel it yields can
  // be registered straight into xOut/yOut; its last flag is registered
  // alongside and therefore describes the pixel currently on the outputs.
  assign geom = segGeom(nextSeg, LEN);

  seg_stepper uStepper (
    .x0   (geom.x0),
    .y0   (geom.y0),
    .dir  (geom.dir),
    .len  (LEN),
    .step (nextStep),
    .dx   (dx),
    .dy   (dy),
    .last (stepLast)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      mask     <= 7'd0;
      seg      <= 3'd0;
      step     <= 4'd0;
      lastReg  <= 1'b0;
      xBase    <= 8'd0;
      yBase    <= 7'd0;
      bus.xOut <= 8'd0;
      bus.yOut <= 7'd0;
      bus.plot <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      state   <= nextState;
      mask    <= nextMask;
      seg     <= nextSeg;
      step    <= nextStep;
      lastReg <= stepLast;
      if (state == ST_IDLE && bus.start) begin
        xBase <= bus.xIn + 8'(X_ORG);
        yBase <= bus.yIn + 7'(Y_ORG);
      end
      bus.plot <= (nextState == ST_DRAW);
      bus.busy <= (nextState != ST_IDLE);
      bus.done <= (nextState == ST_DONE);
      // Coordinates wrap silently; they hold whenever no pixel is emitted.
      if (nextState == ST_DRAW) begin
        bus.xOut <= xBase + {3'b000, dx};
        bus.yOut <= yBase + {2'b00, dy};
      end
    end
  end

endmodule

// File: tb/tb_digit_drawer.sv
module tb_digit_drawer;

  logic clk = 1'b0;
  logic resetn;

  digit_drawer_if u();
  digit_drawer_if h();

  digit_drawer #(.SEG_LEN(7), .X_ORG(11), .Y_ORG(7), .HEX_EN(1)) dut (
    .clk(clk), .resetn(resetn), .bus(u));

  digit_drawer #(.SEG_LEN(7), .X_ORG(11), .Y_ORG(7), .HEX_EN(0)) dutNoHex (
    .clk(clk), .resetn(resetn), .bus(h));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference glyph model for SEG_LEN=7, X_ORG=11, Y_ORG=7
  int mk   [16] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07,
                    'h7F, 'h6F, 'h77, 'h7C, 'h39, 'h5E, 'h79, 'h71};
  int sx   [7]  = '{0, 6, 6, 0, 0, 0, 0};
  int sy   [7]  = '{0, 0, 6, 12, 6, 0, 6};
  int dirY [7]  = '{0, 1, 1, 0, 1, 1, 0};

  typedef struct {
    int dg; int xi; int yi;
    int plots; int busy;
    int fx; int fy; int lx; int ly;
  } vecT;

  vecT vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic runGlyph(input int dg, input int xi, input int yi,
                          input int pokeAt, input int abortPlot,
                          output int plots, output int busyCnt,
                          output int doneCnt, output int doneIdx,
                          output int pixErr,
                          output int fx, output int fy,
                          output int lx, output int ly);
    int expX[$];
    int expY[$];
    int m;
    m = mk[dg];
    for (int s = 0; s < 7; s++) begin
      if (((m >> s) & 1) == 1) begin
        for (int t = 0; t < 7; t++) begin
          expX.push_back((xi + 11 + sx[s] + (dirY[s] ? 0 : t)) % 256);
          expY.push_back((yi + 7 + sy[s] + (dirY[s] ? t : 0)) % 128);
        end
      end
    end
    plots = 0; busyCnt = 0; doneCnt = 0; doneIdx = -1; pixErr = 0;
    fx = -1; fy = -1; lx = -1; ly = -1;
    u.digit = dg[3:0];
    u.xIn   = xi[7:0];
    u.yIn   = yi[6:0];
    u.start = 1'b1;
    tick();
    u.start = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (!u.busy) break;
      busyCnt = k;
      if (u.plot) begin
        if (plots >= expX.size() ||
            int'(u.xOut) != expX[plots] || int'(u.yOut) != expY[plots])
          pixErr++;
        if (plots == 0) begin fx = int'(u.xOut); fy = int'(u.yOut); end
        lx = int'(u.xOut);
        ly = int'(u.yOut);
        plots++;
      end
      if (u.done) begin doneCnt++; doneIdx = k; end
      if (k == pokeAt) begin u.start = 1'b1; u.digit = 4'd8; end
      if (abortPlot > 0 && u.plot && plots == abortPlot) u.abort = 1'b1;
      tick();
      u.start = 1'b0;
      u.abort = 1'b0;
      u.digit = dg[3:0];
    end
  endtask

  initial begin
    int plots, busyCnt, doneCnt, doneIdx, pixErr, fx, fy, lx, ly;

    vecs[0] = '{dg: 7,  xi: 0,   yi: 0,   plots: 21, busy: 26, fx: 11,  fy: 7,  lx: 17,  ly: 19};
    vecs[1] = '{dg: 8,  xi: 0,   yi: 0,   plots: 49, busy: 58, fx: 11,  fy: 7,  lx: 17,  ly: 13};
    vecs[2] = '{dg: 1,  xi: 250, yi: 125, plots: 14, busy: 18, fx: 11,  fy: 4,  lx: 11,  ly: 16};
    vecs[3] = '{dg: 0,  xi: 10,  yi: 20,  plots: 42, busy: 50, fx: 21,  fy: 27, lx: 21,  ly: 33};
    vecs[4] = '{dg: 4,  xi: 0,   yi: 0,   plots: 28, busy: 34, fx: 17,  fy: 7,  lx: 17,  ly: 13};
    vecs[5] = '{dg: 15, xi: 100, yi: 50,  plots: 28, busy: 34, fx: 111, fy: 57, lx: 117, ly: 63};
    vecs[6] = '{dg: 2,  xi: 0,   yi: 0,   plots: 35, busy: 42, fx: 11,  fy: 7,  lx: 17,  ly: 13};
    vecs[7] = '{dg: 12, xi: 0,   yi: 0,   plots: 28, busy: 34, fx: 11,  fy: 7,  lx: 11,  ly: 13};

    resetn = 1'b0;
    u.start = 1'b0; u.abort = 1'b0; u.digit = 4'd0; u.xIn = 8'd0; u.yIn = 7'd0;
    h.start = 1'b0; h.abort = 1'b0; h.digit = 4'd0; h.xIn = 8'd0; h.yIn = 7'd0;
    #2;
    chk("reset_plot", int'(u.plot), 0);
    chk("reset_busy", int'(u.busy), 0);
    chk("reset_done", int'(u.done), 0);
    chk("reset_xOut", int'(u.xOut), 0);
    chk("reset_yOut", int'(u.yOut), 0);
    #1;
    resetn = 1'b1;

    // Table-driven glyphs; the first one is launched on the first edge after reset release.
    for (int i = 0; i < 8; i++) begin
      runGlyph(vecs[i].dg, vecs[i].xi, vecs[i].yi, 0, 0,
               plots, busyCnt, doneCnt, doneIdx, pixErr, fx, fy, lx, ly);
      chk($sformatf("v%0d_plots", i),   plots,   vecs[i].plots);
      chk($sformatf("v%0d_busy", i),    busyCnt, vecs[i].busy);
      chk($sformatf("v%0d_doneCnt", i), doneCnt, 1);
      chk($sformatf("v%0d_doneIdx", i), doneIdx, vecs[i].busy);
      chk($sformatf("v%0d_pixels", i),  pixErr,  0);
      chk($sformatf("v%0d_firstX", i),  fx,      vecs[i].fx);
      chk($sformatf("v%0d_firstY", i),  fy,      vecs[i].fy);
      chk($sformatf("v%0d_lastX", i),   lx,      vecs[i].lx);
      chk($sformatf("v%0d_lastY", i),   ly,      vecs[i].ly);
      chk($sformatf("v%0d_holdX", i),   int'(u.xOut), vecs[i].lx);
      chk($sformatf("v%0d_holdY", i),   int'(u.yOut), vecs[i].ly);
      tick();
    end

    // start pulsed during DRAW (sample 4) is ignored
    runGlyph(7, 0, 0, 4, 0, plots, busyCnt, doneCnt, doneIdx, pixErr, fx, fy, lx, ly);
    chk("poke_plots",  plots,   21);
    chk("poke_busy",   busyCnt, 26);
    chk("poke_done",   doneCnt, 1);
    chk("poke_pixels", pixErr,  0);
    tick();
    chk("poke_noRestart", int'(u.busy), 0);

    // abort at plot #5 of digit 8
    runGlyph(8, 0, 0, 0, 5, plots, busyCnt, doneCnt, doneIdx, pixErr, fx, fy, lx, ly);
    chk("abort_plots",  plots,   5);
    chk("abort_busy",   busyCnt, 6);
    chk("abort_done",   doneCnt, 0);
    chk("abort_plotLo", int'(u.plot), 0);
    chk("abort_doneLo", int'(u.done), 0);
    chk("abort_holdX",  int'(u.xOut), 15);
    chk("abort_pixels", pixErr,  0);
    tick();

    // asynchronous reset in the middle of DRAW
    u.digit = 4'd8; u.xIn = 8'd3; u.yIn = 7'd3; u.start = 1'b1;
    tick();
    u.start = 1'b0;
    repeat (10) tick();
    chk("midDraw_plotHi", int'(u.plot), 1);
    resetn = 1'b0;
    #1;
    chk("rst_plot", int'(u.plot), 0);
    chk("rst_busy", int'(u.busy), 0);
    chk("rst_done", int'(u.done), 0);
    chk("rst_xOut", int'(u.xOut), 0);
    chk("rst_yOut", int'(u.yOut), 0);
    #1;
    resetn = 1'b1;
    runGlyph(7, 0, 0, 0, 0, plots, busyCnt, doneCnt, doneIdx, pixErr, fx, fy, lx, ly);
    chk("rec_plots",  plots,   21);
    chk("rec_busy",   busyCnt, 26);
    chk("rec_pixels", pixErr,  0);

    // HEX_EN=0 blanks digit 12
    h.digit = 4'd12; h.start = 1'b1;
    tick();
    h.start = 1'b0;
    chk("nohex_c1_busy", int'(h.busy), 1);
    chk("nohex_c1_done", int'(h.done), 0);
    chk("nohex_c1_plot", int'(h.plot), 0);
    tick();
    chk("nohex_c2_done", int'(h.done), 1);
    chk("nohex_c2_busy", int'(h.busy), 1);
    chk("nohex_c2_plot", int'(h.plot), 0);
    tick();
    chk("nohex_c3_busy", int'(h.busy), 0);
    chk("nohex_c3_done", int'(h.done), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
